// File: rtl/blink_hex_bank.sv
// Multi-digit 7-segment driver with a programmable blink divider, per-digit
// blink enable, and steady / blink / alternate / off display modes.
module blink_hex_bank #(
    parameter int DIGITS = 6,
    parameter int DIV_W  = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5*DIGITS-1:0] codes,
    input  logic [DIGITS-1:0]   blink_en,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    period,
    output logic [7*DIGITS-1:0] hex,
    output logic                phase,
    output logic                tick
);

    typedef enum logic [1:0] {
        STEADY = 2'b00,
        BLINK  = 2'b01,
        ALT    = 2'b10,
        OFF    = 2'b11
    } mode_t;

    // alphaHex: hex digits 0-F, then a small letter/symbol set; segments {g,f,e,d,c,b,a}, active low
    function automatic logic [6:0] alpha_hex(input logic [4:0] code);
        case (code)
            5'd0:    return 7'b1000000;
            5'd1:    return 7'b1111001;
            5'd2:    return 7'b0100100;
            5'd3:    return 7'b0110000;
            5'd4:    return 7'b0011001;
            5'd5:    return 7'b0010010;
            5'd6:    return 7'b0000010;
            5'd7:    return 7'b1111000;
            5'd8:    return 7'b0000000;
            5'd9:    return 7'b0010000;
            5'd10:   return 7'b0001000;
            5'd11:   return 7'b0000011;
            5'd12:   return 7'b1000110;
            5'd13:   return 7'b0100001;
            5'd14:   return 7'b0000110;
            5'd15:   return 7'b0001110;
            5'd16:   return 7'b0001001;
            5'd17:   return 7'b1000111;
            5'd18:   return 7'b0001100;
            5'd19:   return 7'b1000001;
            5'd20:   return 7'b0101111;
            5'd21:   return 7'b0101011;
            5'd22:   return 7'b0100011;
            5'd23:   return 7'b0000111;
            5'd24:   return 7'b0010001;
            5'd25:   return 7'b0111111;
            5'd26:   return 7'b1000010;
            5'd27:   return 7'b1100001;
            5'd28:   return 7'b1110111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic digit_blank(input mode_t m, input logic en,
                                         input logic ph, input logic odd);
        case (m)
            STEADY:  return 1'b0;
            BLINK:   return en && !ph;
            ALT:     return en && ((ph ^ odd) == 1'b0);
            default: return 1'b1;
        endcase
    endfunction

    mode_t               cur_mode;
    logic [DIV_W-1:0]    count;
    logic [DIV_W-1:0]    eff;
    logic                toggle;
    logic                phase_ns;
    logic [5*DIGITS-1:0] shadow;
    logic [5*DIGITS-1:0] shadow_ns;
    logic [7*DIGITS-1:0] hex_ns;

    assign cur_mode = mode_t'(mode);

    // >= rather than == so a shortened period toggles on the next edge instead of wrapping
    always_comb begin
        eff      = (period == '0) ? DIV_W'(1) : period;
        toggle   = (count >= eff - DIV_W'(1));
        phase_ns = toggle ? ~phase : phase;
    end

    always_comb begin
        shadow_ns = shadow;
        hex_ns    = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (toggle || cur_mode == STEADY)
                shadow_ns[5*d +: 5] = codes[5*d +: 5];
            if (!digit_blank(cur_mode, blink_en[d], phase_ns, d[0]))
                hex_ns[7*d +: 7] = alpha_hex(shadow_ns[5*d +: 5]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            phase  <= 1'b0;
            tick   <= 1'b0;
            shadow <= '0;
            hex    <= '1;
        end else begin
            count  <= toggle ? '0 : count + DIV_W'(1);
            phase  <= phase_ns;
            tick   <= toggle;
            shadow <= shadow_ns;
            hex    <= hex_ns;
        end
    end

endmodule

// File: tb/tb_blink_hex_bank.sv
// Directed self-checking bench for blink_hex_bank (DIGITS=6, DIV_W=26).
module tb_blink_hex_bank;

    localparam int DIGITS = 6;
    localparam int DIV_W  = 26;

    logic                clk;
    logic                reset;
    logic [5*DIGITS-1:0] codes;
    logic [DIGITS-1:0]   blink_en;
    logic [1:0]          mode;
    logic [DIV_W-1:0]    period;
    logic [7*DIGITS-1:0] hex;
    logic                phase;
    logic                tick;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [41:0] ALL_BLANK = 42'h3FF_FFFF_FFFF;
    // code sets, digit 5 in the top slice
    localparam logic [29:0] C1 = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [29:0] C2 = {5'd0, 5'd25, 5'd19, 5'd16, 5'd15, 5'd10};
    localparam logic [29:0] C3 = {5'd14, 5'd13, 5'd12, 5'd11, 5'd9, 5'd8};
    localparam logic [29:0] C5 = {5'd23, 5'd22, 5'd21, 5'd20, 5'd18, 5'd17};
    localparam logic [29:0] C6 = {5'd3, 5'd29, 5'd28, 5'd27, 5'd26, 5'd24};
    localparam logic [29:0] C7 = {6{5'd7}};

    blink_hex_bank #(.DIGITS(DIGITS), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .codes    (codes),
        .blink_en (blink_en),
        .mode     (mode),
        .period   (period),
        .hex      (hex),
        .phase    (phase),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input logic [4:0] c);
        case (c)
            5'd0:  return 7'h40;  5'd1:  return 7'h79;  5'd2:  return 7'h24;
            5'd3:  return 7'h30;  5'd4:  return 7'h19;  5'd5:  return 7'h12;
            5'd6:  return 7'h02;  5'd7:  return 7'h78;  5'd8:  return 7'h00;
            5'd9:  return 7'h10;  5'd10: return 7'h08;  5'd11: return 7'h03;
            5'd12: return 7'h46;  5'd13: return 7'h21;  5'd14: return 7'h06;
            5'd15: return 7'h0E;  5'd16: return 7'h09;  5'd17: return 7'h47;
            5'd18: return 7'h0C;  5'd19: return 7'h41;  5'd20: return 7'h2F;
            5'd21: return 7'h2B;  5'd22: return 7'h23;  5'd23: return 7'h07;
            5'd24: return 7'h11;  5'd25: return 7'h3F;  5'd26: return 7'h42;
            5'd27: return 7'h61;  5'd28: return 7'h77;  default: return 7'h7F;
        endcase
    endfunction

    // expected hex word: decoded codes, with digits in blank_mask forced blank
    function automatic logic [41:0] exp_hex(input logic [29:0] c, input logic [5:0] blank_mask);
        logic [41:0] r;
        for (int d = 0; d < DIGITS; d++)
            r[7*d +: 7] = blank_mask[d] ? 7'h7F : seg(c[5*d +: 5]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [41:0] ehex,
                               input logic ephase, input logic etick);
        check({tag, ".hex"}, 64'(hex), 64'(ehex));
        check({tag, ".phase"}, 64'(phase), 64'(ephase));
        check({tag, ".tick"}, 64'(tick), 64'(etick));
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; period = 26'd3; blink_en = '0; codes = C1;
        #12;
        checkOutput("reset_init", ALL_BLANK, 1'b0, 1'b0);

        @(negedge clk); reset = 1'b0;
        applyStimulus(1);
        check("steady_first", 64'(hex), 64'(exp_hex(C1, 6'b0)));

        // async reset between edges
        #2 reset = 1'b1;
        #1 checkOutput("reset_async", ALL_BLANK, 1'b0, 1'b0);
        mode = 2'b01; period = 26'd3; blink_en = 6'h3F; codes = C2;
        #1 reset = 1'b0;

        applyStimulus(2);
        checkOutput("blink_e2", ALL_BLANK, 1'b0, 1'b0);
        applyStimulus(1);
        checkOutput("blink_e3", exp_hex(C2, 6'b0), 1'b1, 1'b1);
        applyStimulus(1);
        checkOutput("blink_e4", exp_hex(C2, 6'b0), 1'b1, 1'b0);
        applyStimulus(2);
        checkOutput("blink_e6", ALL_BLANK, 1'b0, 1'b1);

        period = 26'd0;
        applyStimulus(1);
        checkOutput("p0_show", exp_hex(C2, 6'b0), 1'b1, 1'b1);
        applyStimulus(1);
        checkOutput("p0_blank", ALL_BLANK, 1'b0, 1'b1);
        period = 26'd1; codes = C3;
        applyStimulus(1);
        checkOutput("p1_show", exp_hex(C3, 6'b0), 1'b1, 1'b1);
        applyStimulus(1);
        checkOutput("p1_blank", ALL_BLANK, 1'b0, 1'b1);

        mode = 2'b10; period = 26'd2; codes = C7;
        applyStimulus(1);
        checkOutput("alt_hold", exp_hex(C3, 6'b010101), 1'b0, 1'b0);
        applyStimulus(1);
        checkOutput("alt_ph1", exp_hex(C7, 6'b101010), 1'b1, 1'b1);
        applyStimulus(2);
        checkOutput("alt_ph0", exp_hex(C7, 6'b010101), 1'b0, 1'b1);

        mode = 2'b01; period = 26'd8; blink_en = 6'b000001;
        applyStimulus(3);
        checkOutput("mix_cnt3", exp_hex(C7, 6'b000001), 1'b0, 1'b0);
        codes = C5;
        applyStimulus(1);
        checkOutput("mix_hold", exp_hex(C7, 6'b000001), 1'b0, 1'b0);
        applyStimulus(4);
        checkOutput("mix_toggle", exp_hex(C5, 6'b0), 1'b1, 1'b1);
        applyStimulus(8);
        checkOutput("mix_blank", exp_hex(C5, 6'b000001), 1'b0, 1'b1);

        mode = 2'b00; codes = C6;
        applyStimulus(1);
        checkOutput("steady_c6", exp_hex(C6, 6'b0), 1'b0, 1'b0);
        codes = C1;
        applyStimulus(1);
        check("steady_c1", 64'(hex), 64'(exp_hex(C1, 6'b0)));
        applyStimulus(6);
        check("steady_tog_phase", 64'(phase), 64'(1'b1));
        codes = C2;
        applyStimulus(1);
        checkOutput("steady_ph1", exp_hex(C2, 6'b0), 1'b1, 1'b0);

        mode = 2'b11;
        applyStimulus(1);
        checkOutput("off_first", ALL_BLANK, 1'b1, 1'b0);
        applyStimulus(6);
        checkOutput("off_toggle", ALL_BLANK, 1'b0, 1'b1);

        mode = 2'b01; blink_en = 6'h3F; period = 26'd100;
        applyStimulus(50);
        checkOutput("shrink_pre", ALL_BLANK, 1'b0, 1'b0);
        period = 26'd10;
        applyStimulus(1);
        checkOutput("shrink_now", exp_hex(C2, 6'b0), 1'b1, 1'b1);
        applyStimulus(9);
        checkOutput("shrink_hold", exp_hex(C2, 6'b0), 1'b1, 1'b0);
        applyStimulus(1);
        checkOutput("shrink_next", ALL_BLANK, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
